// File: rtl/dm_pkg.sv
// Shared constants and types for the data-memory arbiter slice.
package dm_pkg;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 16;
  localparam int DM_DEPTH = 8192;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_id_e;

  typedef enum logic {
    FAV0 = 1'b0,
    FAV1 = 1'b1
  } fav_state_e;

endpackage

// File: rtl/dm_arbiter_if.sv
// Bundle of both requester ports plus the registered DM command/return port.
interface dm_arbiter_if;
  import dm_pkg::*;

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side: takes requests and DM read data, drives grants and DM command.
  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output mem_addr, mem_re, mem_we, mem_wdata
  );

  // Requester/DM side.
  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  mem_addr, mem_re, mem_we, mem_wdata
  );

endinterface

// File: rtl/dm_arb_pick.sv
// Combinational two-way selector: the favored port wins when requesting,
// otherwise the other port wins if it requests.
module dm_arb_pick
  import dm_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  port_id_e fav,
  output logic     gnt0,
  output logic     gnt1
);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (fav == PORT0) begin
      gnt0 = req0;
      gnt1 = req1 & ~req0;
    end else begin
      gnt1 = req1;
      gnt0 = req0 & ~req1;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-ported DM: picks one request per
// cycle, registers it onto the DM port and steers read data back to its owner.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int unsigned STARVE_LIM = 4,
  parameter bit          RR_MODE    = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  dm_arbiter_if.slave bus
);

  localparam logic [0:0] ST_FAV0 = FAV0;
  localparam logic [0:0] ST_FAV1 = FAV1;

  logic [0:0]        state;
  logic [0:0]        state_nx;
  logic [3:0]        starve_cnt;
  logic [3:0]        starve_nx;
  port_id_e          rr_ptr;
  port_id_e          fav;
  port_id_e          owner;
  logic              pick0;
  logic              pick1;
  logic              gnt0;
  logic              gnt1;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_re_q;
  logic              mem_we_q;

  always_comb begin
    fav = PORT0;
    if (RR_MODE) begin
      fav = rr_ptr;
    end else if (state == ST_FAV1) begin
      fav = PORT1;
    end
  end

  dm_arb_pick u_pick (
    .req0 (bus.req0),
    .req1 (bus.req1),
    .fav  (fav),
    .gnt0 (pick0),
    .gnt1 (pick1)
  );

  // Grants are suppressed while reset is asserted so nothing is visible to requesters.
  assign gnt0 = pick0 & rst_n;
  assign gnt1 = pick1 & rst_n;

  // The switch to FAV1 looks at the post-update count so that port 1 wins in
  // the cycle right after its STARVE_LIM-th denial.
  always_comb begin
    starve_nx = 4'd0;
    state_nx  = ST_FAV0;
    if (!RR_MODE) begin
      if (bus.req1 && !gnt1) begin
        starve_nx = (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
      end
      case (state)
        ST_FAV0: state_nx = (starve_nx >= 4'(STARVE_LIM)) ? ST_FAV1 : ST_FAV0;
        default: state_nx = (gnt1 || !bus.req1) ? ST_FAV0 : ST_FAV1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_FAV0;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_nx;
    end
  end

  // The round-robin pointer always ends up on the port that did not just win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= PORT0;
      owner       <= PORT0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
    end else if (gnt1) begin
      rr_ptr      <= PORT0;
      owner       <= PORT1;
      mem_addr_q  <= bus.addr1;
      mem_wdata_q <= bus.wdata1;
      mem_we_q    <= bus.we1;
      mem_re_q    <= ~bus.we1;
    end else if (gnt0) begin
      rr_ptr      <= PORT1;
      owner       <= PORT0;
      mem_addr_q  <= bus.addr0;
      mem_wdata_q <= bus.wdata0;
      mem_we_q    <= bus.we0;
      mem_re_q    <= ~bus.we0;
    end else begin
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;

  // DM read data is live during the cycle after issue; only the owner sees it.
  assign bus.rvalid0 = mem_re_q && (owner == PORT0);
  assign bus.rvalid1 = mem_re_q && (owner == PORT1);
  assign bus.rdata0  = bus.rvalid0 ? bus.mem_rdata : '0;
  assign bus.rdata1  = bus.rvalid1 ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: one fixed-priority and one round-robin
// instance sharing a behavioural DM, checked against a rule-level model.
module tb_dm_arbiter;
  import dm_pkg::*;

  localparam int LIM = 4;

  typedef struct {
    bit              v;
    bit              port;
    bit              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit              known;
  } iss_t;

  typedef struct {
    bit                r0;
    bit                w0;
    logic [ADDR_W-1:0] a0;
    logic [DATA_W-1:0] d0;
    bit                r1;
    bit                w1;
    logic [ADDR_W-1:0] a1;
    logic [DATA_W-1:0] d1;
    bit                eg0;
    bit                eg1;
  } vec_t;

  logic clk;
  logic rst_n;
  logic use_rr;

  logic              s_req0, s_we0, s_req1, s_we1;
  logic [ADDR_W-1:0] s_addr0, s_addr1;
  logic [DATA_W-1:0] s_wdata0, s_wdata1;

  logic              o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_mem_re, o_mem_we;
  logic [DATA_W-1:0] o_rdata0, o_rdata1, o_mem_wdata;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] dm_rdata;
  logic [DATA_W-1:0] dm_mem [DM_DEPTH];

  int   n_cmp = 0;
  int   n_bad = 0;

  bit                m_rr;
  int                m_deny;
  int                m_favor;
  int                dut_wait;
  logic [DATA_W-1:0] ref_mem   [DM_DEPTH];
  bit                ref_known [DM_DEPTH];
  iss_t              exp_cur;
  iss_t              exp_next;

  dm_arbiter_if fp_bus ();
  dm_arbiter_if rr_bus ();

  assign fp_bus.req0      = s_req0 & ~use_rr;
  assign fp_bus.req1      = s_req1 & ~use_rr;
  assign rr_bus.req0      = s_req0 & use_rr;
  assign rr_bus.req1      = s_req1 & use_rr;
  assign fp_bus.we0       = s_we0;
  assign fp_bus.we1       = s_we1;
  assign rr_bus.we0       = s_we0;
  assign rr_bus.we1       = s_we1;
  assign fp_bus.addr0     = s_addr0;
  assign fp_bus.addr1     = s_addr1;
  assign rr_bus.addr0     = s_addr0;
  assign rr_bus.addr1     = s_addr1;
  assign fp_bus.wdata0    = s_wdata0;
  assign fp_bus.wdata1    = s_wdata1;
  assign rr_bus.wdata0    = s_wdata0;
  assign rr_bus.wdata1    = s_wdata1;
  assign fp_bus.mem_rdata = dm_rdata;
  assign rr_bus.mem_rdata = dm_rdata;

  dm_arbiter #(.STARVE_LIM(LIM), .RR_MODE(1'b0)) dut_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fp_bus)
  );

  dm_arbiter #(.STARVE_LIM(LIM), .RR_MODE(1'b1)) dut_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rr_bus)
  );

  assign o_gnt0      = use_rr ? rr_bus.gnt0      : fp_bus.gnt0;
  assign o_gnt1      = use_rr ? rr_bus.gnt1      : fp_bus.gnt1;
  assign o_rvalid0   = use_rr ? rr_bus.rvalid0   : fp_bus.rvalid0;
  assign o_rvalid1   = use_rr ? rr_bus.rvalid1   : fp_bus.rvalid1;
  assign o_rdata0    = use_rr ? rr_bus.rdata0    : fp_bus.rdata0;
  assign o_rdata1    = use_rr ? rr_bus.rdata1    : fp_bus.rdata1;
  assign o_mem_re    = use_rr ? rr_bus.mem_re    : fp_bus.mem_re;
  assign o_mem_we    = use_rr ? rr_bus.mem_we    : fp_bus.mem_we;
  assign o_mem_addr  = use_rr ? rr_bus.mem_addr  : fp_bus.mem_addr;
  assign o_mem_wdata = use_rr ? rr_bus.mem_wdata : fp_bus.mem_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port DM acting on the falling edge, 13-bit decode.
  always @(negedge clk) begin
    if (o_mem_we) dm_mem[o_mem_addr[12:0]] <= o_mem_wdata;
    if (o_mem_re) dm_rdata <= dm_mem[o_mem_addr[12:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Port 1 wins a contested cycle once it has been turned away LIM times in a
  // row (fixed mode) or whenever it is its turn (round-robin mode).
  function automatic int model_winner(bit r0, bit r1);
    if (!r0 && !r1) return -1;
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (m_rr) return m_favor;
    return (m_deny >= LIM) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_deny     = 0;
    m_favor    = 0;
    dut_wait   = 0;
    exp_cur.v  = 1'b0;
    exp_next.v = 1'b0;
  endtask

  task automatic do_reset(input bit rr);
    rst_n    = 1'b0;
    use_rr   = rr;
    m_rr     = rr;
    s_req0   = 1'b0;
    s_req1   = 1'b0;
    s_we0    = 1'b0;
    s_we1    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycle(input bit r0, input bit w0, input logic [ADDR_W-1:0] a0,
                       input logic [DATA_W-1:0] d0, input bit r1, input bit w1,
                       input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                       output bit g0, output bit g1);
    int   win;
    bit   rv0, rv1;
    @(posedge clk);
    #1;
    exp_cur    = exp_next;
    exp_next.v = 1'b0;
    s_req0 = r0; s_we0 = w0; s_addr0 = a0; s_wdata0 = d0;
    s_req1 = r1; s_we1 = w1; s_addr1 = a1; s_wdata1 = d1;
    #1;
    win = model_winner(r0, r1);
    check("gnt0", o_gnt0, win == 0);
    check("gnt1", o_gnt1, win == 1);
    check("gnt_excl", o_gnt0 & o_gnt1, 0);
    g0 = o_gnt0;
    g1 = o_gnt1;
    if (r1 && !o_gnt1) dut_wait++;
    else dut_wait = 0;
    if (r1) check("p1_wait_bound", dut_wait > (m_rr ? 1 : LIM), 0);
    if (r1 && win != 1) m_deny++;
    else m_deny = 0;
    if (win >= 0) begin
      m_favor        = 1 - win;
      exp_next.v     = 1'b1;
      exp_next.port  = (win == 1);
      exp_next.we    = (win == 1) ? w1 : w0;
      exp_next.addr  = (win == 1) ? a1 : a0;
      if (exp_next.we) begin
        exp_next.data  = (win == 1) ? d1 : d0;
        exp_next.known = 1'b1;
        ref_mem[exp_next.addr[12:0]]   = exp_next.data;
        ref_known[exp_next.addr[12:0]] = 1'b1;
      end else begin
        exp_next.data  = ref_mem[exp_next.addr[12:0]];
        exp_next.known = ref_known[exp_next.addr[12:0]];
      end
    end
    @(negedge clk);
    #1;
    check("mem_re", o_mem_re, exp_cur.v && !exp_cur.we);
    check("mem_we", o_mem_we, exp_cur.v && exp_cur.we);
    check("mem_excl", o_mem_re & o_mem_we, 0);
    if (exp_cur.v) check("mem_addr", o_mem_addr, exp_cur.addr);
    if (exp_cur.v && exp_cur.we) check("mem_wdata", o_mem_wdata, exp_cur.data);
    rv0 = exp_cur.v && !exp_cur.we && !exp_cur.port;
    rv1 = exp_cur.v && !exp_cur.we && exp_cur.port;
    check("rvalid0", o_rvalid0, rv0);
    check("rvalid1", o_rvalid1, rv1);
    if (rv0 && exp_cur.known) check("rdata0", o_rdata0, exp_cur.data);
    if (!rv0) check("rdata0_idle", o_rdata0, 0);
    if (rv1 && exp_cur.known) check("rdata1", o_rdata1, exp_cur.data);
    if (!rv1) check("rdata1_idle", o_rdata1, 0);
  endtask

  task automatic soak(input int n);
    bit                p_r0, p_w0, p_r1, p_w1, g0, g1;
    logic [ADDR_W-1:0] p_a0, p_a1;
    logic [DATA_W-1:0] p_d0, p_d1;
    p_r0 = 0; p_r1 = 0; g0 = 0; g1 = 0;
    p_w0 = 0; p_w1 = 0; p_a0 = '0; p_a1 = '0; p_d0 = '0; p_d1 = '0;
    for (int i = 0; i < n; i++) begin
      if (!p_r0 || g0) begin
        p_r0 = ($urandom_range(0, 3) != 0);
        p_w0 = 1'($urandom_range(0, 1));
        p_a0 = 16'($urandom) & 16'hE01F;
        p_d0 = 16'($urandom);
      end
      if (!p_r1 || g1) begin
        p_r1 = ($urandom_range(0, 4) < 3);
        p_w1 = 1'($urandom_range(0, 1));
        p_a1 = 16'($urandom) & 16'hE01F;
        p_d1 = 16'($urandom);
      end
      cycle(p_r0, p_w0, p_a0, p_d0, p_r1, p_w1, p_a1, p_d1, g0, g1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t       tbl [10];
    bit         g0, g1;
    logic [9:0] pat;
    logic [3:0] rr_pat;
    int         g0_count;

    tbl[0] = '{1, 1, 16'h0100, 16'hAAAA, 0, 0, 16'h0000, 16'h0000, 1, 0};
    tbl[1] = '{0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0100, 16'h0000, 0, 1};
    tbl[2] = '{1, 0, 16'h0100, 16'h0000, 1, 1, 16'h0200, 16'h5555, 1, 0};
    tbl[3] = '{0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0200, 16'h5555, 0, 1};
    tbl[4] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0};
    tbl[5] = '{1, 0, 16'h0200, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0};
    tbl[6] = '{1, 0, 16'h0200, 16'h0000, 1, 0, 16'h0200, 16'h0000, 1, 0};
    tbl[7] = '{0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0200, 16'h0000, 0, 1};
    tbl[8] = '{1, 1, 16'h2200, 16'h1111, 0, 0, 16'h0000, 16'h0000, 1, 0};
    tbl[9] = '{0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0200, 16'h0000, 0, 1};

    s_addr0 = '0; s_addr1 = '0; s_wdata0 = '0; s_wdata1 = '0;
    do_reset(1'b0);

    // Reset in the middle of an issued read must kill it without a return.
    cycle(1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, g0, g1);
    check("rst_pre_gnt0", g0, 1);
    @(posedge clk);
    #2;
    check("rst_pre_mem_re", o_mem_re, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mem_re", o_mem_re, 0);
    check("rst_mem_we", o_mem_we, 0);
    check("rst_mem_addr", o_mem_addr, 0);
    check("rst_mem_wdata", o_mem_wdata, 0);
    check("rst_gnt0", o_gnt0, 0);
    check("rst_rvalid0", o_rvalid0, 0);
    check("rst_rdata0", o_rdata0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt0_held", o_gnt0, 0);
    s_req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, g0, g1);
      check("rst_post_rvalid0", o_rvalid0, 0);
    end

    // Table of single-cycle arbitration vectors starting from a cleared counter.
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
            tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1, g0, g1);
      check($sformatf("tbl%0d.gnt0", i), g0, tbl[i].eg0);
      check($sformatf("tbl%0d.gnt1", i), g1, tbl[i].eg1);
    end
    cycle(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, g0, g1);

    // Write then read-back on port 0.
    cycle(1, 1, 16'h0123, 16'hBEEF, 0, 0, 16'h0000, 16'h0000, g0, g1);
    check("wr_gnt0", g0, 1);
    cycle(1, 0, 16'h0123, 16'h0000, 0, 0, 16'h0000, 16'h0000, g0, g1);
    check("rd_gnt0", g0, 1);
    check("wr_issue_we", o_mem_we, 1);
    cycle(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, g0, g1);
    check("rd_issue_re", o_mem_re, 1);
    check("rd_rvalid0", o_rvalid0, 1);
    check("rd_rdata0", o_rdata0, 16'hBEEF);

    // Both ports hammering: port 1 gets every fifth slot.
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 16'h0005, 16'h0000, 1, 0, 16'h0006, 16'h0000, g0, g1);
      pat[i] = g1;
    end
    check("starve_pattern", pat, 10'b10_0001_0000);
    cycle(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, g0, g1);

    // Same-cycle port-1 read and port-0 write; read data goes to port 1 only.
    cycle(0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0040, 16'h1234, g0, g1);
    cycle(1, 1, 16'h0041, 16'h7777, 1, 0, 16'h0040, 16'h0000, g0, g1);
    check("excl_first_gnt0", g0, 1);
    cycle(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0040, 16'h0000, g0, g1);
    check("excl_second_gnt1", g1, 1);
    cycle(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, g0, g1);
    check("excl_rvalid1", o_rvalid1, 1);
    check("excl_rdata1", o_rdata1, 16'h1234);
    check("excl_rvalid0", o_rvalid0, 0);

    soak(10000);

    // Round-robin instance: strict alternation, then a lone requester.
    do_reset(1'b1);
    rr_pat = '0;
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 16'h0007, 16'h0000, 1, 0, 16'h0008, 16'h0000, g0, g1);
      rr_pat[i] = g1;
    end
    check("rr_pattern", rr_pat, 4'b1010);
    g0_count = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 16'h0007, 16'h0000, 0, 0, 16'h0000, 16'h0000, g0, g1);
      if (g0) g0_count++;
    end
    check("rr_idle_gnt0_count", g0_count, 3);

    soak(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
